// File: rtl/cosine_arbiter_pkg.sv
// Shared types and constants for the cosine datapath arbiter.
// Optional statistics counters are enabled with COSINE_ARBITER_STATS_EN.
package cosine_arbiter_pkg;

  localparam int COS_LATENCY = 6;
  localparam int FP_W        = 32;
  localparam int MAX_REQ     = 8;
  localparam int ID_W        = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE,
    INFLIGHT,
    FULL
  } slot_state_e;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requests, the granted index
// becomes lowest priority on the next cycle.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             found;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req[k] && (((int'(ptr) + i) % NUM_REQ) == k)) begin
          grant[k] = 1'b1;
          ptr_nxt  = PTR_W'((k + 1) % NUM_REQ);
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/cosine_arbiter.sv
// Shares one pipelined cosine datapath between NUM_REQ requesters with
// per-requester result slots. Define COSINE_ARBITER_STATS_EN for counters.
module cosine_arbiter
  import cosine_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = COS_LATENCY,
  parameter int DATA_W  = FP_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_angle,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      cos_clk_en,
  output logic [DATA_W-1:0]         cos_angle,
  input  logic [DATA_W-1:0]         cos_result,
  output logic                      busy
`ifdef COSINE_ARBITER_STATS_EN
  ,
  output logic [31:0]               stat_issued,
  output logic [31:0]               stat_stall
`endif
);

  slot_state_e         state     [NUM_REQ];
  slot_state_e         state_nxt [NUM_REQ];
  logic [NUM_REQ-1:0]  idle;
  logic [NUM_REQ-1:0]  eligible;
  logic                accept;
  logic [ID_W-1:0]     grant_id;
  logic [DATA_W-1:0]   angle_sel;
  tag_t                iss_p0;
  tag_t                tag_p [LATENCY];
  tag_t                cap;

  // Nothing is granted while reset is held so req_ready reads 0 immediately.
  always_comb begin
    idle = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idle[k] = (state[k] == IDLE);
    end
    eligible = req_valid & idle & {NUM_REQ{~reset}};
  end

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk  (clk),
    .reset(reset),
    .req  (eligible),
    .grant(req_ready)
  );

  always_comb begin
    accept    = |req_ready;
    grant_id  = '0;
    angle_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k]) begin
        grant_id  = ID_W'(k);
        angle_sel = req_angle[k*DATA_W +: DATA_W];
      end
    end
  end

  // Issue stage: iss_p0 travels with cos_angle, then LATENCY tag stages
  // line up the final tag with the datapath result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cos_angle <= '0;
      iss_p0    <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        tag_p[s] <= '0;
      end
    end else begin
      if (accept) begin
        cos_angle <= angle_sel;
      end
      iss_p0.v  <= accept;
      iss_p0.id <= grant_id;
      tag_p[0]  <= iss_p0;
      for (int s = 1; s < LATENCY; s++) begin
        tag_p[s] <= tag_p[s-1];
      end
    end
  end

  assign cap = tag_p[LATENCY-1];

  // The capture edge itself needs no datapath advance, so the last stage is
  // left out of the enable.
  always_comb begin
    cos_clk_en = accept | iss_p0.v;
    for (int s = 0; s < LATENCY - 1; s++) begin
      cos_clk_en = cos_clk_en | tag_p[s].v;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        state[k] <= IDLE;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        state[k] <= state_nxt[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      state_nxt[k] = state[k];
      case (state[k])
        IDLE:     if (req_ready[k]) state_nxt[k] = INFLIGHT;
        INFLIGHT: if (cap.v && (cap.id == ID_W'(k))) state_nxt[k] = FULL;
        FULL:     if (rsp_ready[k]) state_nxt[k] = IDLE;
        default:  state_nxt[k] = IDLE;
      endcase
    end
  end

  // Result slots keep their value after a pop until the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (cap.v && (cap.id == ID_W'(k))) begin
          rsp_data[k*DATA_W +: DATA_W] <= cos_result;
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_valid[k] = (state[k] == FULL);
    end
    busy = ~(&idle);
  end

`ifdef COSINE_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if ((|req_valid) && !accept) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cosine_arbiter.sv
// Randomized and directed bench for cosine_arbiter against a slot-level
// reference model, with a behavioural cosine datapath attached.
module tb_cosine_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_angle = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_ready = '0;
  logic        cos_clk_en;
  logic [31:0] cos_angle;
  logic [31:0] cos_result;
  logic        busy;
`ifdef COSINE_ARBITER_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  cosine_arbiter #(
    .NUM_REQ(2),
    .LATENCY(6),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .cos_clk_en(cos_clk_en),
    .cos_angle (cos_angle),
    .cos_result(cos_result),
    .busy      (busy)
`ifdef COSINE_ARBITER_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] a);
    if (a[30:23] == 8'd0) return 0.0;
    return $bitstoreal({a[31], 11'({3'b000, a[30:23]} + 11'd896), a[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [30:0] mag;
    b = $realtobits(r);
    if (b[62:52] < 11'd897) return {b[63], 31'b0};
    mag = {8'(b[62:52] - 11'd896), b[51:29]} + 31'(b[28]);
    return {b[63], mag};
  endfunction

  function automatic logic [31:0] cosf(input logic [31:0] a);
    return r2f($cos(f2r(a)));
  endfunction

  function automatic logic [31:0] lane(input logic [63:0] v, input int k);
    return (k == 0) ? v[31:0] : v[63:32];
  endfunction

  function automatic logic [31:0] rand_angle();
    return {1'($urandom), 8'(120 + $urandom_range(0, 8)), 23'($urandom)};
  endfunction

  // Datapath stand-in: six enabled stages, cleared whenever clk_en is low.
  logic [31:0] dp [6];
  always @(posedge clk) begin
    if (!cos_clk_en) begin
      for (int i = 0; i < 6; i++) dp[i] <= '0;
    end else begin
      dp[0] <= cosf(cos_angle);
      for (int i = 1; i < 6; i++) dp[i] <= dp[i-1];
    end
  end
  assign cos_result = dp[5];

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic near(input string tag, input logic [31:0] got, input real target);
    real d;
    d = f2r(got) - target;
    if (d < 0.0) d = -d;
    check(tag, {32'h0, got}, (d < 1.0 / 1048576.0) ? {32'h0, got} : {32'h0, r2f(target)});
  endtask

  // Reference model: slot state 0=idle 1=waiting 2=holding result.
  int          mstate [2];
  int          mdue   [2];
  logic [31:0] mexp   [2];
  int          ptr, n, issued, stalls;
  int          gcnt [2];
  int          last_g, alt_err;

  task automatic model_clear();
    for (int k = 0; k < 2; k++) mstate[k] = 0;
    ptr = 0;
    issued = 0;
    stalls = 0;
  endtask

  task automatic step(input logic [1:0] v, input logic [63:0] a, input logic [1:0] rdy);
    int g, kk;
    logic [1:0] er, ev;
    logic een, ebusy;
    @(negedge clk);
    req_valid = v;
    req_angle = a;
    rsp_ready = rdy;
    #1;
    g = -1;
    for (int i = 0; i < 2; i++) begin
      kk = (ptr + i) % 2;
      if (g < 0 && v[kk] && mstate[kk] == 0) g = kk;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    ev = '0;
    een = (g >= 0);
    ebusy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (mstate[k] == 2) ev[k] = 1'b1;
      if (mstate[k] == 1 && mdue[k] > n) een = 1'b1;
      if (mstate[k] != 0) ebusy = 1'b1;
    end
    check("req_ready", req_ready, er);
    check("rsp_valid", rsp_valid, ev);
    for (int k = 0; k < 2; k++)
      if (mstate[k] == 2) check("rsp_data", lane(rsp_data, k), mexp[k]);
    check("cos_clk_en", cos_clk_en, een);
    check("busy", busy, ebusy);
`ifdef COSINE_ARBITER_STATS_EN
    check("stat_issued", stat_issued, issued);
    check("stat_stall", stat_stall, stalls);
`endif
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (mstate[k] == 2 && rdy[k]) mstate[k] = 0;
      else if (mstate[k] == 1 && mdue[k] == n) mstate[k] = 2;
    end
    if (g >= 0) begin
      mstate[g] = 1;
      mdue[g] = n + 7;
      mexp[g] = cosf(lane(a, g));
      ptr = (g + 1) % 2;
      issued++;
      gcnt[g]++;
      if (g == last_g) alt_err++;
      last_g = g;
    end else if (v != 2'b00) begin
      stalls++;
    end
    n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rsp_ready = '0;
    #2;
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_clk_en", cos_clk_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_cos_angle", cos_angle, 0);
`ifdef COSINE_ARBITER_STATS_EN
    check("rst_stats", {stat_issued, stat_stall}, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int g0;
    int diff;
`ifdef COSINE_ARBITER_STATS_EN
    logic [31:0] s0;
`endif
    n = 0;
    last_g = -1;
    alt_err = 0;
    gcnt[0] = 0;
    gcnt[1] = 0;
    model_clear();
    do_reset();

    // Single request, cos(1.0)
    step(2'b01, {32'h0, 32'h3F800000}, 2'b00);
    repeat (7) step(2'b00, 64'h0, 2'b00);
    #1;
    check("single_rsp_valid", rsp_valid, 2'b01);
    near("single_cos1", rsp_data[31:0], 0.5403023058681398);
    step(2'b00, 64'h0, 2'b01);
    step(2'b00, 64'h0, 2'b00);

    // Simultaneous requests right after reset
    do_reset();
    step(2'b11, {32'h3FC90FDB, 32'h00000000}, 2'b00);
    step(2'b11, {32'h3FC90FDB, 32'h00000000}, 2'b00);
    repeat (7) step(2'b00, 64'h0, 2'b00);
    #1;
    check("simul_rsp_valid", rsp_valid, 2'b11);
    near("simul_cos0", rsp_data[31:0], 1.0);
    near("simul_cos_pi2", rsp_data[63:32], 0.0);
    step(2'b00, 64'h0, 2'b11);

    // Back-pressure on requester 1
    g0 = gcnt[0];
    for (int i = 0; i < 45; i++) step(2'b11, {rand_angle(), rand_angle()}, 2'b01);
    #1;
    check("bp_r1_blocked", req_ready[1], 1'b0);
    check("bp_r0_progress", (gcnt[0] - g0) >= 4, 1'b1);
    repeat (10) step(2'b00, 64'h0, 2'b11);

    // Fairness with both continuously valid
    gcnt[0] = 0;
    gcnt[1] = 0;
    last_g = -1;
    alt_err = 0;
    for (int i = 0; i < 100; i++) step(2'b11, {rand_angle(), rand_angle()}, 2'b11);
    diff = gcnt[0] - gcnt[1];
    if (diff < 0) diff = -diff;
    check("fair_alternate", alt_err, 0);
    check("fair_balance", diff <= 1, 1'b1);
    check("fair_activity", (gcnt[0] + gcnt[1]) >= 20, 1'b1);
`ifdef COSINE_ARBITER_STATS_EN
    #1;
    check("fair_stat_issued", stat_issued, issued);
`endif
    repeat (10) step(2'b00, 64'h0, 2'b11);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(2'($urandom), {rand_angle(), rand_angle()}, 2'($urandom));
    repeat (10) step(2'b00, 64'h0, 2'b11);

    // Reset while an operation is in flight
    step(2'b01, {32'h0, rand_angle()}, 2'b00);
    repeat (3) step(2'b00, 64'h0, 2'b00);
    do_reset();
    repeat (12) step(2'b00, 64'h0, 2'b11);

`ifdef COSINE_ARBITER_STATS_EN
    // Stall counting with requester 1 blocked by its full slot
    step(2'b10, {rand_angle(), 32'h0}, 2'b00);
    repeat (8) step(2'b00, 64'h0, 2'b00);
    #1;
    s0 = stat_stall;
    repeat (10) step(2'b10, {rand_angle(), 32'h0}, 2'b00);
    #1;
    check("stall_delta", stat_stall - s0, 32'd10);
    repeat (3) step(2'b00, 64'h0, 2'b11);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
